// File: rtl/crop_pack.sv
// Column-crop window plus dense repack of grouped raster data, zero-padding the last group.
// Define CROP_PACK_CHECK_EN to build the sticky overflow / bad-config error flag.
module crop_pack #(
    parameter int unsigned GROUP_SIZE = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LOG_MAX_W  = 10,
    parameter int unsigned LOG_MAX_H  = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             configure,
    input  logic [LOG_MAX_W-1:0]             w_in,
    input  logic [LOG_MAX_H-1:0]             h_in,
    input  logic [LOG_MAX_W-1:0]             w_start,
    input  logic [LOG_MAX_W-1:0]             w_out,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
    input  logic                             valid_in,
    output logic                             avail_out,
    output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
    output logic                             valid_out,
    input  logic                             avail_in,
    output logic                             done,
    output logic                             error
);
    localparam int unsigned GS  = GROUP_SIZE;
    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned GW  = GROUP_SIZE * DATA_WIDTH;
    localparam int unsigned CW  = $clog2(2 * GROUP_SIZE + 1);
    localparam int unsigned AIW = $clog2(2 * GROUP_SIZE);
    localparam int unsigned CBW = LOG_MAX_W + 1;
    localparam int unsigned RW  = LOG_MAX_H + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e               r_state, w_state_d;
    logic [GW-1:0]        r_fifo [4];
    logic [1:0]           r_wr_ptr, r_rd_ptr;
    logic [2:0]           r_fifo_cnt;
    logic [DW-1:0]        r_acc [2*GS];
    logic [DW-1:0]        w_acc_d [2*GS];
    logic [CW-1:0]        r_count, w_count_d, w_cnt_after_emit, w_idx;
    logic [CBW-1:0]       r_col_base, w_col_step;
    logic [LOG_MAX_H-1:0] r_row;
    logic [LOG_MAX_W-1:0] r_w_in, r_w_start;
    logic [LOG_MAX_H-1:0] r_h_in;
    logic [CBW-1:0]       r_w_end;

    logic                 w_full, w_empty, w_push, w_pop, w_emit, w_cnt_ge_gs, w_col_wrap;
    logic [GW-1:0]        w_head;
    logic [GS-1:0]        w_keep, w_last, w_lane_wrap;
    logic [CBW-1:0]       w_lane_sum [GS];
    logic [CBW-1:0]       w_lane_col [GS];
    logic [RW-1:0]        w_lane_row [GS];

    assign w_full    = (r_fifo_cnt == 3'd4);
    assign w_empty   = (r_fifo_cnt == 3'd0);
    assign w_push    = valid_in & ~w_full;
    assign avail_out = (r_fifo_cnt < 3'd3);
    assign w_head    = r_fifo[r_rd_ptr];

    assign w_cnt_ge_gs = (r_count >= CW'(GS));
    assign w_emit      = avail_in & (w_cnt_ge_gs | ((r_state == StFlush) & (r_count != '0)));
    assign w_cnt_after_emit = !w_emit ? r_count : (w_cnt_ge_gs ? r_count - CW'(GS) : '0);
    // Only pop when the survivors are guaranteed to fit in the 2*GS accumulator.
    assign w_pop = (r_state == StRun) & ~w_empty & (w_cnt_after_emit <= CW'(GS));

    assign valid_out = w_emit;
    assign done      = (r_state == StFlush) & (r_count == '0);

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            r_fifo_cnt <= r_fifo_cnt + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // Column/row of each lane in the head group; at most one row wrap per group.
    always_comb begin
        w_keep      = '0;
        w_last      = '0;
        w_lane_wrap = '0;
        for (int i = 0; i < GS; i++) begin
            w_lane_sum[i]  = r_col_base + CBW'(i);
            w_lane_wrap[i] = (w_lane_sum[i] >= {1'b0, r_w_in});
            w_lane_col[i]  = w_lane_wrap[i] ? w_lane_sum[i] - {1'b0, r_w_in} : w_lane_sum[i];
            w_lane_row[i]  = {1'b0, r_row} + RW'(w_lane_wrap[i]);
            w_keep[i] = (w_lane_col[i] >= {1'b0, r_w_start}) && (w_lane_col[i] < r_w_end)
                        && (w_lane_row[i] < {1'b0, r_h_in});
            w_last[i] = (w_lane_row[i] == {1'b0, r_h_in} - RW'(1))
                        && (w_lane_col[i] == {1'b0, r_w_in} - CBW'(1));
        end
    end

    assign w_col_step = r_col_base + CBW'(GS);
    assign w_col_wrap = (w_col_step >= {1'b0, r_w_in});

    // Slots at or above count are kept zero, so data_out needs no masking.
    always_comb begin
        w_acc_d   = r_acc;
        w_count_d = w_cnt_after_emit;
        w_idx     = w_cnt_after_emit;
        if (w_emit) begin
            for (int j = 0; j < GS; j++) begin
                w_acc_d[j]      = r_acc[j+GS];
                w_acc_d[j+GS]   = '0;
            end
        end
        if (w_pop) begin
            for (int i = 0; i < GS; i++) begin
                if (w_keep[i]) begin
                    w_acc_d[w_idx[AIW-1:0]] = w_head[i*DW +: DW];
                    w_idx = w_idx + CW'(1);
                end
            end
            w_count_d = w_idx;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  w_state_d = StIdle;
            StRun:   if (w_pop && (w_last != '0)) w_state_d = StFlush;
            StFlush: if (r_count == '0) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < GS; i++) data_out[i*DW +: DW] = r_acc[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_col_base <= '0;
            r_row      <= '0;
            r_w_in     <= '0;
            r_h_in     <= '0;
            r_w_start  <= '0;
            r_w_end    <= '0;
            for (int j = 0; j < 2*GS; j++) r_acc[j] <= '0;
        end else if (configure) begin
            r_state    <= StRun;
            r_count    <= '0;
            r_col_base <= '0;
            r_row      <= '0;
            r_w_in     <= w_in;
            r_h_in     <= h_in;
            r_w_start  <= w_start;
            r_w_end    <= {1'b0, w_start} + {1'b0, w_out};
            for (int j = 0; j < 2*GS; j++) r_acc[j] <= '0;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_acc   <= w_acc_d;
            if (w_pop) begin
                r_col_base <= w_col_wrap ? w_col_step - {1'b0, r_w_in} : w_col_step;
                if (w_col_wrap) r_row <= r_row + LOG_MAX_H'(1);
            end
        end
    end

`ifdef CROP_PACK_CHECK_EN
    logic r_error;
    logic w_cfg_bad;
    assign w_cfg_bad = (w_in < LOG_MAX_W'(GS)) | (h_in == '0) | (w_out == '0)
                       | (({1'b0, w_start} + {1'b0, w_out}) > {1'b0, w_in});
    always_ff @(posedge clk) begin
        if (rst) r_error <= 1'b0;
        else if ((valid_in & w_full) | (configure & w_cfg_bad)) r_error <= 1'b1;
    end
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_crop_pack.sv
// Directed self-checking bench for crop_pack with GROUP_SIZE=4.
module tb_crop_pack;
    localparam int GS = 4;
    localparam int DW = 8;
    localparam int GW = GS * DW;

    logic          clk = 1'b0;
    logic          rst, configure, valid_in, avail_in;
    logic [9:0]    w_in, w_start, w_out;
    logic [9:0]    h_in;
    logic [GW-1:0] data_in, data_out;
    logic          avail_out, valid_out, done, error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [GW-1:0] out_q[$];
    int            out_cyc[$];
    int            done_cnt, done_cyc;

    crop_pack #(.GROUP_SIZE(GS), .DATA_WIDTH(DW), .LOG_MAX_W(10), .LOG_MAX_H(10)) u_dut (
        .clk(clk), .rst(rst), .configure(configure), .w_in(w_in), .h_in(h_in),
        .w_start(w_start), .w_out(w_out), .data_in(data_in), .valid_in(valid_in),
        .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
        .avail_in(avail_in), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) begin
                out_q.push_back(data_out);
                out_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [GW-1:0] pk(input int a, input int b, input int c, input int d);
        pk = {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Case-1 frame: items 0..24 then pad lanes that must never survive.
    function automatic logic [GW-1:0] grp1(input int g);
        int k = 4 * g;
        grp1 = pk(k < 25 ? k : 8'hEE, k + 1 < 25 ? k + 1 : 8'hEE,
                  k + 2 < 25 ? k + 2 : 8'hEE, k + 3 < 25 ? k + 3 : 8'hEE);
    endfunction

    function automatic logic [GW-1:0] seq(input int base, input int g);
        seq = pk(base + 4 * g, base + 4 * g + 1, base + 4 * g + 2, base + 4 * g + 3);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        out_q.delete();
        out_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; configure = 1'b0; valid_in = 1'b0; avail_in = 1'b0; data_in = '0;
        w_in = '0; h_in = '0; w_start = '0; w_out = '0;
        step();
        step();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic cfg(input int wi, input int hi, input int ws, input int wo);
        w_in = wi[9:0]; h_in = hi[9:0]; w_start = ws[9:0]; w_out = wo[9:0];
        configure = 1'b1;
        step();
        configure = 1'b0;
    endtask

    task automatic send(input logic [GW-1:0] d);
        data_in = d;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: done not seen within %0d cycles", name, bound);
        end
        repeat (3) step();
    endtask

    task automatic check_crop_out(input string name);
        logic [GW-1:0] exp_q [4];
        logic [GW-1:0] got;
        exp_q[0] = pk(2, 3, 4, 7);
        exp_q[1] = pk(8, 9, 12, 13);
        exp_q[2] = pk(14, 17, 18, 19);
        exp_q[3] = pk(22, 23, 24, 0);
        checks++;
        if (out_q.size() != 4) begin
            errors++;
            $display("FAIL %s_count: got %0d groups expected 4", name, out_q.size());
        end
        for (int j = 0; j < 4; j++) begin
            got = (j < out_q.size()) ? out_q[j] : 'x;
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL %s_grp%0d: got %h expected %h", name, j, got, exp_q[j]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done_cnt: got %0d expected 1", name, done_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        avail_in = 1'b1;
        #1;
        checks += 5;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid_out); end
        if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        if (error !== 1'b0)     begin errors++; $display("FAIL rst_error: got %b expected 0", error); end
        if (data_out !== '0)    begin errors++; $display("FAIL rst_data: got %h expected 0", data_out); end
        if (avail_out !== 1'b1) begin errors++; $display("FAIL rst_avail: got %b expected 1", avail_out); end
    endtask

    task automatic test_crop();
        int last;
        do_reset();
        avail_in = 1'b1;
        cfg(5, 5, 2, 3);
        for (int g = 0; g < 7; g++) send(grp1(g));
        wait_done(40, "crop");
        check_crop_out("crop");
        last = (out_cyc.size() > 0) ? out_cyc[out_cyc.size()-1] : -10;
        checks++;
        if (done_cyc != last + 1) begin
            errors++;
            $display("FAIL crop_done_time: got cycle %0d expected %0d", done_cyc, last + 1);
        end
    endtask

    task automatic test_passthrough();
        int wr_cyc [4];
        logic [GW-1:0] got;
        int gc;
        do_reset();
        avail_in = 1'b1;
        cfg(8, 2, 0, 8);
        for (int g = 0; g < 4; g++) begin
            wr_cyc[g] = cyc;
            send(seq(8'h40, g));
        end
        wait_done(30, "pass");
        checks++;
        if (out_q.size() != 4) begin
            errors++;
            $display("FAIL pass_count: got %0d groups expected 4", out_q.size());
        end
        for (int g = 0; g < 4; g++) begin
            got = (g < out_q.size()) ? out_q[g] : 'x;
            gc  = (g < out_cyc.size()) ? out_cyc[g] : -1;
            checks += 2;
            if (got !== seq(8'h40, g)) begin
                errors++;
                $display("FAIL pass_grp%0d: got %h expected %h", g, got, seq(8'h40, g));
            end
            if (gc != wr_cyc[g] + 2) begin
                errors++;
                $display("FAIL pass_lat%0d: got cycle %0d expected %0d", g, gc, wr_cyc[g] + 2);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL pass_done_cnt: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        logic saw_low = 1'b0;
        int held_out = -1;
        do_reset();
        avail_in = 1'b0;
        cfg(5, 5, 2, 3);
        for (int k = 0; k < 80; k++) begin
            if (k == 20) held_out = out_q.size();
            avail_in = (k >= 20);
            if (!avail_out) saw_low = 1'b1;
            if (sent < 7 && avail_out) begin
                data_in = grp1(sent);
                valid_in = 1'b1;
                sent++;
            end else begin
                valid_in = 1'b0;
            end
            step();
            valid_in = 1'b0;
            if (sent == 7 && k >= 20) break;
        end
        wait_done(40, "bp");
        checks += 3;
        if (saw_low !== 1'b1) begin errors++; $display("FAIL bp_avail_low: got %b expected 1", saw_low); end
        if (sent != 7) begin errors++; $display("FAIL bp_sent: got %0d expected 7", sent); end
        if (held_out != 0) begin errors++; $display("FAIL bp_stall_out: got %0d expected 0", held_out); end
        check_crop_out("bp");
    endtask

    task automatic test_reconfig();
        logic [GW-1:0] got;
        do_reset();
        avail_in = 1'b0;
        cfg(5, 5, 2, 3);
        send(grp1(0));
        send(grp1(1));
        step();
        step();
        clear_mon();
        cfg(8, 2, 0, 8);
        avail_in = 1'b1;
        for (int g = 0; g < 4; g++) send(seq(8'h80, g));
        wait_done(30, "recfg");
        checks += 2;
        if (out_q.size() != 4) begin
            errors++;
            $display("FAIL recfg_count: got %0d groups expected 4", out_q.size());
        end
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL recfg_done_cnt: got %0d expected 1", done_cnt);
        end
        for (int g = 0; g < 4; g++) begin
            got = (g < out_q.size()) ? out_q[g] : 'x;
            checks++;
            if (got !== seq(8'h80, g)) begin
                errors++;
                $display("FAIL recfg_grp%0d: got %h expected %h", g, got, seq(8'h80, g));
            end
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        avail_in = 1'b0;
        cfg(4, 1, 0, 2);
        send(pk(8'h11, 8'h22, 8'h33, 8'h44));
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        avail_in = 1'b1;
        clear_mon();
        repeat (6) step();
        checks += 3;
        if (out_q.size() != 0) begin
            errors++;
            $display("FAIL rflush_valid: got %0d emits expected 0", out_q.size());
        end
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL rflush_done: got %0d pulses expected 0", done_cnt);
        end
        if (data_out !== '0) begin
            errors++;
            $display("FAIL rflush_data: got %h expected 0", data_out);
        end
    endtask

    task automatic test_overflow();
        logic          exp_err;
        logic [GW-1:0] got;
`ifdef CROP_PACK_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        for (int g = 0; g < 5; g++) send(seq(8'hA0, g));
        checks += 2;
        if (avail_out !== 1'b0) begin errors++; $display("FAIL ovf_avail: got %b expected 0", avail_out); end
        if (error !== exp_err) begin errors++; $display("FAIL ovf_error: got %b expected %b", error, exp_err); end
        avail_in = 1'b1;
        cfg(4, 4, 0, 4);
        wait_done(30, "ovf");
        checks += 2;
        if (out_q.size() != 4) begin
            errors++;
            $display("FAIL ovf_count: got %0d groups expected 4", out_q.size());
        end
        if (error !== exp_err) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", error, exp_err); end
        for (int g = 0; g < 4; g++) begin
            got = (g < out_q.size()) ? out_q[g] : 'x;
            checks++;
            if (got !== seq(8'hA0, g)) begin
                errors++;
                $display("FAIL ovf_grp%0d: got %h expected %h", g, got, seq(8'hA0, g));
            end
        end
    endtask

    initial begin
        rst = 1'b1; configure = 1'b0; valid_in = 1'b0; avail_in = 1'b0; data_in = '0;
        w_in = '0; h_in = '0; w_start = '0; w_out = '0;
        done_cnt = 0; done_cyc = -1;
        test_reset();
        test_crop();
        test_passthrough();
        test_backpressure();
        test_reconfig();
        test_reset_flush();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/crop_pack.md
# crop_pack

Column-crop and repack stage placed directly downstream of the align stage. It receives a raster-ordered frame as groups of GROUP_SIZE items and keeps only the items whose column lies inside a configured window. Surviving items are repacked densely into full GROUP_SIZE groups, and the frame's last partial group is zero-padded. It uses the same configure / valid / avail conventions as its neighbours.

## Interface
- GROUP_SIZE, 8, items per group (in and out)
- DATA_WIDTH, 8, bits per item
- LOG_MAX_W, 10, width of column-related config fields
- LOG_MAX_H, 10, width of row-count field
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- configure  in  1  one-cycle config strobe
- w_in  in  LOG_MAX_W  input frame width; must be ≥ GROUP_SIZE
- h_in  in  LOG_MAX_H  input frame rows; must be ≥ 1
- w_start  in  LOG_MAX_W  first kept column
- w_out  in  LOG_MAX_W  kept columns; w_out ≥ 1 and w_start+w_out ≤ w_in
- data_in  in  GROUP_SIZE*DATA_WIDTH  input group; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- valid_in  in  1  write strobe
- avail_out  out  1  input can accept; ~almost_full & ~full of the input FIFO
- data_out  out  GROUP_SIZE*DATA_WIDTH  output group, same lane order as data_in
- valid_out  out  1  group transferred this cycle
- avail_in  in  1  downstream can accept
- done  out  1  one-cycle pulse after the final group of a frame
- error  out  1  sticky check flag (see Configuration)

## Operation
- Input FIFO: 4 slots, GROUP_SIZE*DATA_WIDTH wide. Writes on valid_in. A write while the FIFO is full is dropped.
- Accumulator: 2*GROUP_SIZE item slots plus a count register, 0..2*GROUP_SIZE.
- States:
  - IDLE: entered from reset and after a frame completes.
  - RUN: entered on configure.
  - FLUSH: entered after the group containing the frame's last item has been popped.
- configure is accepted in any state. It loads the config fields, clears col/row counters and the accumulator, and enters RUN. FIFO contents are kept.
- Position tracking: col_base and row registers. In the popped group, lane i has column c = col_base+i. If c ≥ w_in, the lane's column is c−w_in on row+1; at most one wrap per group.
- A lane is kept iff its column lies in [w_start, w_start+w_out) and its item index is < w_in*h_in.
- Kept lanes are appended to the accumulator at slots count.. in ascending lane order.
- Emit condition: valid_out = avail_in & (count ≥ GS | (FLUSH & count > 0)).
  - data_out = accumulator slots 0..GS−1. Slots ≥ count are driven as 0.
  - On emit, the accumulator shifts down by GS and count decreases by min(count, GS).
- Pop condition: RUN & ~empty & (count − GS·emit ≤ GS). At most one pop per cycle. Pop and emit may occur in the same cycle: new count = count − GS·emit + kept.
- In RUN, popping the group that holds row h_in−1, column w_in−1 moves the block to FLUSH. Lanes after that item are discarded.
- FLUSH ends when count reaches 0. The block then goes to IDLE and pulses done for one cycle. If count is already 0 when FLUSH is entered, done pulses in the next cycle.
- In IDLE and FLUSH there are no pops. FIFO data stays queued for the next configure.
- Counter arithmetic: col_base is LOG_MAX_W+1 bits to hold the pre-wrap sum. Row uses LOG_MAX_H bits and wraps via the end-of-frame check only.

## Timing
- Reset values:
  - Outputs: valid_out=0, done=0, error=0, data_out=0, avail_out=1.
  - Internal: FIFO empty, count=0, state IDLE.
- rst mid-frame aborts the frame. Queued FIFO data and accumulator contents are lost.
- FIFO: a write in cycle t is visible (not empty) in t+1.
- Latency: an input group written in cycle t can first be emitted in cycle t+2, provided avail_in is high.
- Throughput: one input and one output group per cycle when GS items are kept per group.
- valid_out is combinational from state, count and avail_in. data_out comes from registers.
- avail_out drops as soon as 3 slots are occupied. This gives the producer one cycle of slack.

## Configuration
- CROP_PACK_CHECK_EN defined: error is set and held until rst in either of two cases:
  - a write while the FIFO is full;
  - a configure whose fields violate w_in ≥ GS, h_in ≥ 1, w_out ≥ 1, or w_start+w_out ≤ w_in.
- CROP_PACK_CHECK_EN undefined: error is tied to 0 and the check logic is not built. Behaviour under violations is undefined.

## Test plan
- Crop and repack:
  - Setup: GS=4, w_in=5, h_in=5, w_start=2, w_out=3. Feed items 0..24 plus 3 pad lanes (7 groups); avail_in=1.
  - Expected outputs: (2,3,4,7), (8,9,12,13), (14,17,18,19), (22,23,24,0).
  - done pulses one cycle after the last group.
- Passthrough:
  - Setup: w_in=8, h_in=2, w_start=0, w_out=8, GS=4. Feed 4 groups back-to-back.
  - Expected: 4 identical groups out, each 2 cycles after its write, with no bubbles.
- Backpressure:
  - Setup: case 1 with avail_in=0 for 20 cycles.
  - Expected: avail_out falls once 3 FIFO slots are used, with no loss. Releasing avail_in yields identical output.
- Reconfigure mid-frame: configure after 2 input groups. Expected: accumulator cleared, new frame's output correct, no done for the aborted frame.
- Reset mid-frame: assert rst during FLUSH. Expected: valid_out=0 next cycle, no done, count=0.
- Overflow check (CROP_PACK_CHECK_EN defined): 5 writes with no configure. Expected: the fifth is dropped and error=1 until rst.
